// File: rtl/div_mon_pkg.sv
// Shared types and sizing helpers for the divided-clock monitor.
package div_mon_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACQ = 2'd1, LOCK = 2'd2} mon_state_t;

  localparam int ERR_CNT_W = 16;

  // Counter width: large enough for TMO+1 = 4*ndiv+1
  function automatic int cnt_w(input int ndiv);
    return $clog2(4 * ndiv + 1) + 1;
  endfunction
endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for ckd followed by a rising-edge detect flop.
module sync_edge_det (
  input  logic cki,
  input  logic rst,
  input  logic ckd,
  output logic s,
  output logic rise
);
  logic meta, s_d;

  always_ff @(posedge cki or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      s    <= 1'b0;
      s_d  <= 1'b0;
    end else begin
      meta <= ckd;
      s    <= meta;
      s_d  <= s;
    end
  end

  assign rise = s & ~s_d;
endmodule

// File: rtl/div_clk_monitor.sv
// Measures period/high time of ckd in cki cycles, tracks lock against Ndiv,
// and reports bad periods and stuck-clock timeouts.
module div_clk_monitor
  import div_mon_pkg::*;
#(
  parameter  int Ndiv    = 2,
  parameter  int Nlock   = 4,
  parameter  int Nunlock = 2,
  parameter  int Ntol    = 0,
  localparam int Nw      = cnt_w(Ndiv)
) (
  input  logic                 cki,
  input  logic                 rst,
  input  logic                 ckd,
  output logic [Nw-1:0]        period,
  output logic [Nw-1:0]        high_time,
  output logic                 period_vld,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);
  localparam logic [Nw-1:0] TMO      = Nw'(4 * Ndiv);
  localparam logic [Nw-1:0] TMO_M1   = Nw'(4 * Ndiv - 1);
  localparam logic [Nw-1:0] HIGH_EXP = Nw'(Ndiv - (Ndiv >> 1));
  localparam int PLO = (Ndiv > Ntol) ? Ndiv - Ntol : 0;
  localparam int PHI = Ndiv + Ntol;
  localparam int MW  = $clog2(Nlock + 1);
  localparam int SW  = $clog2(Nunlock + 1);

  logic          s, rise;
  logic [Nw-1:0] cntr, hcnt, per1;
  int            per_i;
  logic          good, bad, tmo;
  mon_state_t    st, nxt;
  logic [MW-1:0] mcnt, mcnt_n;
  logic [SW-1:0] miss, miss_n;

  sync_edge_det u_sync (.cki(cki), .rst(rst), .ckd(ckd), .s(s), .rise(rise));

  assign per1  = cntr + 1'b1;
  assign per_i = int'(per1);
  assign good  = (per_i >= PLO) && (per_i <= PHI) && (hcnt == HIGH_EXP);

  always_comb begin
    nxt    = st;
    mcnt_n = mcnt;
    miss_n = miss;
    bad    = 1'b0;
    tmo    = 1'b0;
    case (st)
      IDLE: if (rise) begin
        nxt    = ACQ;
        mcnt_n = '0;
      end
      ACQ: if (rise) begin
        if (good) begin
          mcnt_n = mcnt + 1'b1;
          if (mcnt == MW'(Nlock - 1)) begin
            nxt    = LOCK;
            miss_n = '0;
          end
        end else begin
          mcnt_n = '0;
          bad    = 1'b1;
        end
      end else if (cntr == TMO_M1) begin
        nxt = IDLE;
        tmo = 1'b1;
      end
      LOCK: if (rise) begin
        if (good) miss_n = '0;
        else begin
          bad    = 1'b1;
          miss_n = miss + 1'b1;
          if (miss == SW'(Nunlock - 1)) begin
            nxt    = ACQ;
            mcnt_n = '0;
          end
        end
      end else if (cntr == TMO_M1) begin
        nxt = IDLE;
        tmo = 1'b1;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge cki or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      mcnt       <= '0;
      miss       <= '0;
      cntr       <= '0;
      hcnt       <= '0;
      period     <= '0;
      high_time  <= '0;
      period_vld <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_cnt    <= '0;
    end else begin
      st   <= nxt;
      mcnt <= mcnt_n;
      miss <= miss_n;
      if (rise) begin
        cntr <= '0;
        hcnt <= Nw'(1);
      end else begin
        if (cntr != TMO) cntr <= cntr + 1'b1;
        if (s && hcnt != TMO) hcnt <= hcnt + 1'b1;
      end
      // The first rise after IDLE only arms; no measurement is reported
      period_vld <= rise && (st != IDLE);
      if (rise && st != IDLE) begin
        period    <= per1;
        high_time <= hcnt;
      end
      locked <= (nxt == LOCK);
      err    <= bad | tmo;
      if ((bad | tmo) && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_div_clk_monitor.sv
// Randomized and directed bench for div_clk_monitor with an event-level reference model.
module tb_div_clk_monitor;
  localparam int NDIV = 4, NLOCK = 4, NUNLOCK = 2, NTOL = 0;
  localparam int TMO = 4 * NDIV;
  localparam int NW  = $clog2(4 * NDIV + 1) + 1;

  logic          cki = 1'b0, rst = 1'b1, ckd = 1'b0;
  logic [NW-1:0] period, high_time;
  logic          period_vld, locked, err;
  logic [15:0]   err_cnt;

  div_clk_monitor #(.Ndiv(NDIV), .Nlock(NLOCK), .Nunlock(NUNLOCK), .Ntol(NTOL)) dut (
    .cki(cki), .rst(rst), .ckd(ckd), .period(period), .high_time(high_time),
    .period_vld(period_vld), .locked(locked), .err(err), .err_cnt(err_cnt)
  );

  always #5 cki = ~cki;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: works on rise events and cycle indices
  typedef enum {M_IDLE, M_ACQ, M_LOCK} mstate_e;
  mstate_e mst = M_IDLE;
  int  k = 0, last_rise = 0, hi_acc = 0, mc = 0, ms = 0, per = 0;
  bit  h0 = 0, h1 = 0, h2 = 0, mrise, good, fault;
  int  e_period = 0, e_high = 0, e_cnt = 0;
  bit  e_pv = 0, e_err = 0, e_lock = 0;

  initial forever begin
    @(posedge cki);
    if (rst) begin
      mst = M_IDLE; k = 0; last_rise = 0; hi_acc = 0; mc = 0; ms = 0;
      h0 = 0; h1 = 0; h2 = 0;
      e_period = 0; e_high = 0; e_cnt = 0; e_pv = 0; e_err = 0; e_lock = 0;
    end else begin
      // ckd sampled n-1 posedges ago is the synchronized level this cycle
      mrise = h1 & ~h2;
      e_pv = 0;
      fault = 0;
      if (mrise) begin
        if (mst == M_IDLE) begin
          mst = M_ACQ; mc = 0;
        end else begin
          per = k - last_rise;
          e_pv = 1; e_period = per; e_high = hi_acc;
          good = (per >= NDIV - NTOL) && (per <= NDIV + NTOL) && (hi_acc == NDIV - NDIV / 2);
          if (mst == M_ACQ) begin
            if (good) begin
              mc++;
              if (mc == NLOCK) begin mst = M_LOCK; ms = 0; end
            end else begin
              mc = 0; fault = 1;
            end
          end else begin
            if (good) ms = 0;
            else begin
              ms++; fault = 1;
              if (ms == NUNLOCK) begin mst = M_ACQ; mc = 0; end
            end
          end
        end
        last_rise = k;
        hi_acc = 1;
      end else begin
        hi_acc += int'(h1);
        if (mst != M_IDLE && k - last_rise == TMO) begin
          mst = M_IDLE; fault = 1;
        end
      end
      e_err = fault;
      if (fault && e_cnt < 65535) e_cnt++;
      e_lock = (mst == M_LOCK);
      h2 = h1; h1 = h0; h0 = ckd; k++;
    end
  end

  initial forever begin
    @(negedge cki);
    if (rst) begin
      chk("rst_outputs", {period_vld, locked, err, period, high_time, err_cnt}, 32'd0);
    end else begin
      chk("period_vld", period_vld, e_pv);
      chk("locked", locked, e_lock);
      chk("err", err, e_err);
      chk("err_cnt", err_cnt, e_cnt);
      chk("period", period, e_period);
      chk("high_time", high_time, e_high);
    end
  end

  task automatic chunk(input int lo, input int hi);
    repeat (lo) begin @(negedge cki); ckd = 1'b0; end
    repeat (hi) begin @(negedge cki); ckd = 1'b1; end
  endtask

  task automatic ideal(input int n);
    repeat (n) chunk(2, 2);
  endtask

  int r;

  initial begin
    repeat (3) @(negedge cki);
    #1;
    chk("lit_reset_locked", locked, 1'b0);
    chk("lit_reset_errcnt", err_cnt, 16'd0);
    @(negedge cki); rst = 1'b0;

    // ideal /4 locks
    ideal(8);
    chk("lit_ideal_locked", locked, 1'b1);
    chk("lit_ideal_period", period, 4);
    chk("lit_ideal_high", high_time, 2);
    chk("lit_ideal_errcnt", err_cnt, 0);

    // one /5 period while locked: err but stays locked
    chunk(3, 2); ideal(2);
    chk("lit_one_bad_errcnt", err_cnt, 1);
    chk("lit_one_bad_locked", locked, 1'b1);

    // two bad periods drop lock, then relock
    chunk(3, 2); chunk(3, 2); ideal(2);
    chk("lit_two_bad_errcnt", err_cnt, 3);
    chk("lit_two_bad_locked", locked, 1'b0);
    ideal(5);
    chk("lit_relock", locked, 1'b1);

    // stuck low: timeout
    repeat (22) begin @(negedge cki); ckd = 1'b0; end
    chk("lit_tmo_errcnt", err_cnt, 4);
    chk("lit_tmo_locked", locked, 1'b0);
    ideal(6);
    chk("lit_tmo_relock", locked, 1'b1);

    // random periods and duties
    repeat (400) begin
      r = $urandom_range(99);
      if (r < 60)      chunk(2, 2);
      else if (r < 85) chunk($urandom_range(1, 4), $urandom_range(1, 4));
      else if (r < 95) chunk($urandom_range(5, 8), $urandom_range(1, 3));
      else             chunk($urandom_range(17, 20), 2);
    end

    // reset mid-LOCK
    ideal(8);
    chk("lit_pre_rst_locked", locked, 1'b1);
    @(posedge cki); #2 rst = 1'b1; ckd = 1'b0;
    #1;
    chk("lit_async_rst_locked", locked, 1'b0);
    chk("lit_async_rst_errcnt", err_cnt, 0);
    chk("lit_async_rst_period", period, 0);
    repeat (3) @(negedge cki);
    rst = 1'b0;
    ideal(4);
    chk("lit_post_rst_not_yet", locked, 1'b0);
    chunk(2, 2); chunk(2, 0);
    chk("lit_post_rst_locked", locked, 1'b1);
    chk("lit_post_rst_errcnt", err_cnt, 0);
    chunk(0, 2); ideal(2);

    repeat (4) @(negedge cki);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
